// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between an issuing pipeline and mul_div_unit
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        double_en;
    logic [63:0] double_wdata;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, double_en, double_wdata
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, double_en, double_wdata
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32x32 multiply / restoring divide, HI/LO result; MDU_FAST_MUL_EN selects single-cycle multiply
module mul_div_unit (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        is_div_q;
    logic        neg_lo_q;
    logic        neg_hi_q;
    logic [63:0] wdata_q;

    logic        accept;
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;
    logic        skip_calc;

    assign accept    = (state_q == IDLE) && bus.start && !bus.flush;
    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.src_a[31];
    assign b_neg     = signed_op & bus.src_b[31];
    assign mag_a     = a_neg ? (32'd0 - bus.src_a) : bus.src_a;
    assign mag_b     = b_neg ? (32'd0 - bus.src_b) : bus.src_b;
    assign div_zero  = bus.op[1] && (bus.src_b == 32'd0);

`ifdef MDU_FAST_MUL_EN
    assign skip_calc = div_zero || !bus.op[1];
`else
    assign skip_calc = div_zero;
`endif

    // acc_q holds {HI, LO}: product-in-progress with multiplier in LO, or remainder/quotient for divide
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic [63:0] div_next;

    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next  = {mul_sum, acc_q[31:1]};
    assign rem_shift = {acc_q[63:32], acc_q[31]};
    assign rem_diff  = rem_shift - {1'b0, opnd_q};
    assign div_next  = rem_diff[32] ? {rem_shift[31:0], acc_q[30:0], 1'b0}
                                    : {rem_diff[31:0],  acc_q[30:0], 1'b1};

    logic [31:0] lo_fix;
    logic [31:0] hi_fix;
    logic [63:0] prod_fix;
    logic [63:0] result;

    assign lo_fix   = neg_lo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    assign hi_fix   = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    assign prod_fix = neg_lo_q ? (64'd0 - acc_q)        : acc_q;
    assign result   = is_div_q ? {hi_fix, lo_fix} : prod_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = skip_calc ? FIN : CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'd31) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            wdata_q  <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q    <= 5'd0;
                        is_div_q <= bus.op[1];
                        neg_lo_q <= a_neg ^ b_neg;
                        neg_hi_q <= bus.op[1] & a_neg;
                        if (div_zero) begin
                            // Divide-by-zero result is fixed: HI = raw dividend, LO = all ones
                            acc_q    <= {bus.src_a, 32'hFFFF_FFFF};
                            neg_lo_q <= 1'b0;
                            neg_hi_q <= 1'b0;
                        end else if (bus.op[1]) begin
                            acc_q  <= {32'd0, mag_a};
                            opnd_q <= mag_b;
                        end else begin
`ifdef MDU_FAST_MUL_EN
                            acc_q  <= {32'd0, mag_a} * {32'd0, mag_b};
`else
                            acc_q  <= {32'd0, mag_b};
`endif
                            opnd_q <= mag_a;
                        end
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                FIN: begin
                    if (!bus.flush) begin
                        wdata_q <= result;
                    end
                end
                default: begin
                    cnt_q <= 5'd0;
                end
            endcase
        end
    end

    // The corrected result is presented in the FIN cycle itself so it lines up with the strobe
    logic fin_ok;
    assign fin_ok           = (state_q == FIN) && !bus.flush && !rst;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = fin_ok;
    assign bus.double_en    = fin_ok;
    assign bus.double_wdata = fin_ok ? result : wdata_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic clk;
    logic rst;
    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [63:0] exp);
        int lat;
        @(negedge clk);
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.src_a = ~a;
        bus.src_b = b ^ 32'h5A5A_5A5A;
        lat = 1;
        while (!bus.done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, bus.double_wdata, exp);
        chk({tag, "_en"}, {63'd0, bus.double_en}, 64'd1);
        // a start arriving in the FIN cycle must be dropped
        @(negedge clk);
        bus.op    = OP_MULTU;
        bus.src_b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, "_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
        chk({tag, "_hold"}, bus.double_wdata, exp);
    endtask

    initial begin
        int cyc;
        logic saw_en;
        logic [63:0] prev;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {61'd0, bus.busy, bus.done, bus.double_en}, 64'd0);
        chk("reset_wdata", bus.double_wdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, MUL_LAT, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 64'h4000_0000_0000_0000);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 64'h0000_0000_8000_0000);
        run_op("div_nn", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, DIV_LAT, 64'hFFFF_FFFE_0000_000E);
        run_op("div_pn", OP_DIV, 32'd100, 32'hFFFF_FFF9, DIV_LAT, 64'h0000_0002_FFFF_FFF2);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, DIV_LAT, 64'h0000_0002_0000_000E);
        run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 1, 64'h0000_1234_FFFF_FFFF);
        run_op("div_zero", OP_DIV, 32'hFFFF_FFF0, 32'd0, 1, 64'hFFFF_FFF0_FFFF_FFFF);

        // flush during CALC, with an extra start delivered while busy
        prev   = 64'h0000_1234_FFFF_FFFF;
        prev   = 64'hFFFF_FFF0_FFFF_FFFF;
        saw_en = 1'b0;
        @(negedge clk);
        bus.op    = OP_DIVU;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            if (cyc == 5) begin
                bus.op    = OP_MULTU;
                bus.src_a = 32'd3;
                bus.src_b = 32'd3;
                bus.start = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.double_en) saw_en = 1'b1;
            cyc++;
        end
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy", {63'd0, bus.busy}, 64'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.double_en || bus.done) saw_en = 1'b1;
        end
        chk("flush_no_en", {63'd0, saw_en}, 64'd0);
        chk("flush_hold", bus.double_wdata, prev);

        // flush together with start in IDLE blocks acceptance
        @(negedge clk);
        bus.op    = OP_DIVU;
        bus.src_a = 32'd9;
        bus.src_b = 32'd3;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_blk", {63'd0, bus.busy}, 64'd0);

        // reset in the middle of a multiply
        @(negedge clk);
        bus.op    = OP_MULT;
        bus.src_a = 32'h0001_2345;
        bus.src_b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_outs", {61'd0, bus.busy, bus.done, bus.double_en}, 64'd0);
        chk("rst_wdata", bus.double_wdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("mult_after_rst", OP_MULT, 32'd7, 32'hFFFF_FFFA, MUL_LAT, 64'hFFFF_FFFF_FFFF_FFD6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port src_a  input  32  multiplicand or dividend.
REQ-006 SHALL have port src_b  input  32  multiplier or divisor.
REQ-007 SHALL have port flush  input  1  abort the operation in progress; no result written.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port double_en  output  1  HI/LO write strobe to the register file; identical to done.
REQ-011 SHALL have port double_wdata  output  64  result: [63:32] HI, [31:0] LO.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and FIN.
REQ-013 IDLE: when start=1 and flush=0, SHALL latch op and operand magnitudes, record the result signs, clear the 5-bit iteration counter, and enter CALC.
REQ-014 CALC: SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle; after counter value 31 it SHALL enter FIN.
REQ-015 FIN: SHALL apply sign correction, register double_wdata, pulse done/double_en for exactly one cycle, then return to IDLE.
REQ-016 Latency SHALL be 33 cycles: done is high in the 33rd cycle after the cycle in which start was accepted.
REQ-017 Multiply result SHALL be the full 64-bit product: signed for MULT, unsigned for MULTU.
REQ-018 Divide result SHALL be LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign; DIVU is unsigned.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000 (wrap, no trap).
REQ-020 Divide by zero (src_b=0) SHALL skip CALC (IDLE->FIN), with done one cycle after start; result SHALL be LO=0xFFFFFFFF, HI=src_a.
REQ-021 start while busy=1 (including the FIN cycle) SHALL be ignored.
REQ-022 flush=1 in CALC or FIN SHALL return the FSM to IDLE next cycle with no done/double_en; flush=1 together with start in IDLE SHALL block acceptance.
REQ-023 double_wdata SHALL hold its last value between completions and after a flush.
REQ-024 Operands SHALL be captured at acceptance; src_a/src_b changes afterwards SHALL NOT affect the result.

Reset
REQ-025 rst=1 SHALL force IDLE, counter=0, busy=0, done=0, double_en=0 and double_wdata=0 on the next rising edge.
REQ-026 rst during CALC or FIN SHALL abandon the operation with no write strobe.
REQ-027 rst SHALL take priority over start and flush.

Configuration
REQ-028 Macro MDU_FAST_MUL_EN: when defined, MULT/MULTU SHALL compute the product in a single cycle (IDLE->FIN, done one cycle after acceptance); DIV/DIVU remain iterative.
REQ-029 Without MDU_FAST_MUL_EN, all multiplies SHALL use the 33-cycle iterative path; results SHALL be bit-identical in both builds.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> double_wdata=0xFFFFFFFE_00000001, done at cycle 33 (at cycle 1 with MDU_FAST_MUL_EN).
REQ-031 MULT 0xFFFFFFFD(-3) x 5 -> double_wdata=0xFFFFFFFF_FFFFFFF1, with one-cycle double_en.
REQ-032 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 DIVU 0x1234 / 0 -> done one cycle after start; LO=0xFFFFFFFF, HI=0x00001234.
REQ-034 Start DIVU 100/7, assert flush at cycle 10 -> busy drops next cycle, no double_en, double_wdata unchanged; a second start (delivered while busy) is ignored.
REQ-035 Assert rst at cycle 20 of a MULT -> all outputs zero next cycle; a new start after reset completes correctly.
